// File: rtl/rs_sched_pkg.sv
// Shared types for the Reed-Solomon decode scheduler: outcome codes, FSM states
// and the bit layout of the 34-bit resolver result word.
`timescale 1ns/1ps
package rs_sched_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FAIL  = 2'd3
  } status_e;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_e;

  localparam int RES_W          = 34;
  localparam int RES_STATUS_LSB = 32;
  localparam int RES_RD_LSB     = 24;
  localparam int RES_RA_LSB     = 16;
  localparam int RES_RB_LSB     = 8;
  localparam int RES_RC_LSB     = 0;

  typedef struct packed {
    status_e    status;
    logic [7:0] loc0;
    logic [7:0] val0;
    logic [7:0] loc1;
    logic [7:0] val1;
  } cor_rec_t;

  // A single error reports its location/value in rd/ra; a double error puts
  // the first one in rb/rc and the second in rd/ra.
  function automatic cor_rec_t unpack_result(input logic [RES_W-1:0] res);
    cor_rec_t rec;
    rec = '0;
    rec.status = status_e'(res[RES_STATUS_LSB +: 2]);
    case (rec.status)
      ST_ONE: begin
        rec.loc0 = res[RES_RD_LSB +: 8];
        rec.val0 = res[RES_RA_LSB +: 8];
      end
      ST_TWO: begin
        rec.loc0 = res[RES_RB_LSB +: 8];
        rec.val0 = res[RES_RC_LSB +: 8];
        rec.loc1 = res[RES_RD_LSB +: 8];
        rec.val1 = res[RES_RA_LSB +: 8];
      end
      default: ;
    endcase
    return rec;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rs_syn_fifo.sv
// Syndrome-set FIFO: registered occupancy count, head word readable without a pop.
`timescale 1ns/1ps
module rs_syn_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Callers never write when full or read when empty, so no guards here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/rs_decode_scheduler.sv
// Queues syndrome sets, dispatches them one at a time to the two-error resolver
// and turns each result into a tagged correction record with outcome statistics.
`timescale 1ns/1ps
module rs_decode_scheduler
  import rs_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAGW    = 8,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [7:0]       syn_s0,
  input  logic [7:0]       syn_s1,
  input  logic [7:0]       syn_s2,
  input  logic [7:0]       syn_s3,
  input  logic [TAGW-1:0]  syn_tag,
  output logic             rs_syn_ready,
  output logic [7:0]       rs_si0,
  output logic [7:0]       rs_si1,
  output logic [7:0]       rs_si2,
  output logic [7:0]       rs_si3,
  input  logic [RES_W-1:0] rs_results,
  input  logic             rs_done,
  output logic             cor_valid,
  input  logic             cor_ready,
  output logic [1:0]       cor_status,
  output logic [7:0]       cor_loc0,
  output logic [7:0]       cor_val0,
  output logic [7:0]       cor_loc1,
  output logic [7:0]       cor_val1,
  output logic [TAGW-1:0]  cor_tag,
  output logic             cor_timeout,
  input  logic             stat_clr,
  output logic [15:0]      cnt_clean,
  output logic [15:0]      cnt_corr,
  output logic [15:0]      cnt_fail
);

  localparam int EW = 32 + TAGW;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                 state;
  logic [TW-1:0]          timer;
  logic [TAGW-1:0]        cur_tag;
  logic                   hold_to;
  cor_rec_t               cor_q;
  cor_rec_t               new_rec;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   unused_count;
  logic [EW-1:0]          head;
  logic                   dispatch, timer_hit, wait_fin, wait_to, out_free, load, load_to;

  rs_syn_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (syn_valid && !fifo_full),
    .wr_data ({syn_tag, syn_s3, syn_s2, syn_s1, syn_s0}),
    .rd_en   (dispatch),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_count = ^fifo_count;
  assign syn_ready    = !fifo_full;

  // Dispatch is combinational so a set arriving at an idle scheduler reaches
  // the resolver in the very next cycle; the syndrome bus is zero otherwise.
  assign dispatch     = (state == S_IDLE) && !fifo_empty && rs_done;
  assign rs_syn_ready = dispatch;
  assign {rs_si3, rs_si2, rs_si1, rs_si0} = dispatch ? head[31:0] : 32'd0;

  assign timer_hit = (timer == TW'(TIMEOUT - 1));
  assign wait_fin  = (state == S_WAIT) && (rs_done || timer_hit);
  assign wait_to   = (state == S_WAIT) && !rs_done && timer_hit;
  assign out_free  = !cor_valid || cor_ready;
  assign load      = (wait_fin && out_free) || ((state == S_HOLD) && cor_ready);
  assign load_to   = (state == S_HOLD) ? hold_to : wait_to;

  always_comb begin
    new_rec = unpack_result(rs_results);
    if (load_to) begin
      new_rec        = '0;
      new_rec.status = ST_FAIL;
    end
  end

  // A record that cannot be handed over yet parks the FSM in HOLD; a timed-out
  // frame then still has to see the resolver go idle (DRAIN) before redispatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      cur_tag     <= '0;
      hold_to     <= 1'b0;
      cor_q       <= '0;
      cor_valid   <= 1'b0;
      cor_tag     <= '0;
      cor_timeout <= 1'b0;
    end else begin
      if (cor_valid && cor_ready) cor_valid <= 1'b0;
      if (load) begin
        cor_valid   <= 1'b1;
        cor_q       <= new_rec;
        cor_tag     <= cur_tag;
        cor_timeout <= load_to;
      end
      case (state)
        S_IDLE: begin
          if (dispatch) begin
            cur_tag <= head[EW-1:32];
            timer   <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_fin) begin
            hold_to <= wait_to;
            if (out_free) state <= wait_to ? S_DRAIN : S_IDLE;
            else          state <= S_HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (cor_ready) state <= hold_to ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (rs_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_clean <= '0;
      cnt_corr  <= '0;
      cnt_fail  <= '0;
    end else if (stat_clr) begin
      cnt_clean <= '0;
      cnt_corr  <= '0;
      cnt_fail  <= '0;
    end else if (load) begin
      case (new_rec.status)
        ST_CLEAN:      cnt_clean <= sat_inc(cnt_clean);
        ST_ONE, ST_TWO: cnt_corr <= sat_inc(cnt_corr);
        default:       cnt_fail  <= sat_inc(cnt_fail);
      endcase
    end
  end

  assign cor_status = cor_q.status;
  assign cor_loc0   = cor_q.loc0;
  assign cor_val0   = cor_q.val0;
  assign cor_loc1   = cor_q.loc1;
  assign cor_val1   = cor_q.val1;

endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Directed bench for rs_decode_scheduler with a hand-driven resolver stub.
`timescale 1ns/1ps
module tb_rs_decode_scheduler;

  localparam int TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        reset;
  logic        syn_valid, syn_ready;
  logic [7:0]  syn_s0, syn_s1, syn_s2, syn_s3, syn_tag;
  logic        rs_syn_ready;
  logic [7:0]  rs_si0, rs_si1, rs_si2, rs_si3;
  logic [33:0] rs_results;
  logic        rs_done;
  logic        cor_valid, cor_ready;
  logic [1:0]  cor_status;
  logic [7:0]  cor_loc0, cor_val0, cor_loc1, cor_val1, cor_tag;
  logic        cor_timeout, stat_clr;
  logic [15:0] cnt_clean, cnt_corr, cnt_fail;

  int   n_vec = 0;
  int   n_err = 0;
  int   n, k;
  logic found, saw, acc;

  always #5 clk = ~clk;

  rs_decode_scheduler #(.DEPTH(4), .TAGW(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .syn_valid(syn_valid), .syn_ready(syn_ready),
    .syn_s0(syn_s0), .syn_s1(syn_s1), .syn_s2(syn_s2), .syn_s3(syn_s3), .syn_tag(syn_tag),
    .rs_syn_ready(rs_syn_ready),
    .rs_si0(rs_si0), .rs_si1(rs_si1), .rs_si2(rs_si2), .rs_si3(rs_si3),
    .rs_results(rs_results), .rs_done(rs_done),
    .cor_valid(cor_valid), .cor_ready(cor_ready), .cor_status(cor_status),
    .cor_loc0(cor_loc0), .cor_val0(cor_val0), .cor_loc1(cor_loc1), .cor_val1(cor_val1),
    .cor_tag(cor_tag), .cor_timeout(cor_timeout),
    .stat_clr(stat_clr), .cnt_clean(cnt_clean), .cnt_corr(cnt_corr), .cnt_fail(cnt_fail)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check_output("rst_syn_ready", syn_ready, 1);
    check_output("rst_rs_syn_ready", rs_syn_ready, 0);
    check_output("rst_rs_si", {rs_si3, rs_si2, rs_si1, rs_si0}, 0);
    check_output("rst_cor_valid", cor_valid, 0);
    check_output("rst_cor_fields", {cor_status, cor_loc0, cor_val0, cor_loc1, cor_val1, cor_tag, cor_timeout}, 0);
    check_output("rst_counters", {cnt_clean, cnt_corr, cnt_fail}, 0);
  endtask

  task automatic check_record(input logic [7:0] tag, input logic [1:0] st, input logic [7:0] l0,
                              input logic [7:0] v0, input logic [7:0] l1, input logic [7:0] v1,
                              input logic to);
    check_output("rec_valid", cor_valid, 1);
    check_output("rec_status", cor_status, st);
    check_output("rec_locval", {cor_loc0, cor_val0, cor_loc1, cor_val1}, {l0, v0, l1, v1});
    check_output("rec_tag", cor_tag, tag);
    check_output("rec_timeout", cor_timeout, to);
  endtask

  // Offer one set to an idle scheduler, hold rs_done low for lat WAIT cycles,
  // then return res; returns in the cycle the record should be visible.
  task automatic apply_stimulus(input logic [7:0] tag, input logic [31:0] syn, input int lat,
                                input logic [33:0] res);
    syn_valid = 1'b1;
    syn_tag   = tag;
    {syn_s3, syn_s2, syn_s1, syn_s0} = syn;
    rs_done   = 1'b1;
    @(negedge clk);
    check_output("offer_ready", syn_ready, 1);
    check_output("offer_no_dispatch", rs_syn_ready, 0);
    next_cycle();
    syn_valid = 1'b0;
    @(negedge clk);
    check_output("dispatch", rs_syn_ready, 1);
    check_output("dispatch_syn", {rs_si3, rs_si2, rs_si1, rs_si0}, syn);
    next_cycle();
    for (int i = 0; i < lat; i++) begin
      rs_done = 1'b0;
      next_cycle();
    end
    rs_done    = 1'b1;
    rs_results = res;
    @(negedge clk);
    check_output("preload_valid", cor_valid, 0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0; syn_valid = 1'b0; syn_tag = '0;
    {syn_s3, syn_s2, syn_s1, syn_s0} = '0;
    rs_results = '0; rs_done = 1'b1; cor_ready = 1'b1; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // clean frame: dispatch N+1, record N+3
    apply_stimulus(8'h11, 32'h0, 0, 34'h0);
    @(negedge clk);
    check_record(8'h11, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("clean_cnt", cnt_clean, 1);
    next_cycle();

    apply_stimulus(8'h22, 32'h04030201, 10, 34'h1_05_3C_00_00);
    @(negedge clk);
    check_record(8'h22, 2'd1, 8'h05, 8'h3C, 8'h00, 8'h00, 1'b0);
    check_output("one_cnt", cnt_corr, 1);
    next_cycle();

    apply_stimulus(8'h33, 32'hA1B2C3D4, 3, 34'h2_0A_77_03_19);
    @(negedge clk);
    check_record(8'h33, 2'd2, 8'h03, 8'h19, 8'h0A, 8'h77, 1'b0);
    check_output("two_cnt", cnt_corr, 2);
    next_cycle();

    // resolver that never finishes
    syn_valid = 1'b1; syn_tag = 8'h44; {syn_s3, syn_s2, syn_s1, syn_s0} = 32'hDEADBEEF;
    @(negedge clk);
    next_cycle();
    syn_valid = 1'b0;
    @(negedge clk);
    check_output("to_dispatch", rs_syn_ready, 1);
    next_cycle();
    rs_done = 1'b0;
    n = 0; found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cor_valid) begin
        found = 1'b1;
        break;
      end
      next_cycle();
      n++;
    end
    check_output("to_found", found, 1);
    check_output("to_latency_ok", (n >= TIMEOUT && n <= TIMEOUT + 1), 1);
    check_record(8'h44, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    check_output("to_cnt_fail", cnt_fail, 1);
    next_cycle();
    syn_valid = 1'b1; syn_tag = 8'h55; {syn_s3, syn_s2, syn_s1, syn_s0} = 32'h01020304;
    @(negedge clk);
    next_cycle();
    syn_valid = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw |= rs_syn_ready;
      next_cycle();
    end
    check_output("drain_block", saw, 0);
    rs_done = 1'b1; rs_results = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rs_syn_ready) break;
      next_cycle();
    end
    check_output("drain_release", rs_syn_ready, 1);
    check_output("drain_syn", {rs_si3, rs_si2, rs_si1, rs_si0}, 32'h01020304);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_record(8'h55, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("drain_cnt_clean", cnt_clean, 2);
    next_cycle();

    // five frames with downstream stalled and resolver busy
    rs_done = 1'b0; cor_ready = 1'b0; rs_results = '0;
    for (int i = 0; i < 4; i++) begin
      syn_valid = 1'b1; syn_tag = 8'(8'h61 + i);
      {syn_s3, syn_s2, syn_s1, syn_s0} = 32'(i);
      @(negedge clk);
      check_output("fill_ready", syn_ready, 1);
      next_cycle();
    end
    syn_tag = 8'h65;
    @(negedge clk);
    check_output("fifo_full", syn_ready, 0);
    next_cycle();
    rs_done = 1'b1;
    for (int c = 0; c < 10 && syn_valid; c++) begin
      @(negedge clk);
      acc = syn_ready;
      next_cycle();
      if (acc) syn_valid = 1'b0;
    end
    check_output("fifth_accepted", syn_valid, 0);
    repeat (4) next_cycle();
    @(negedge clk);
    check_output("hold_valid", cor_valid, 1);
    check_output("hold_tag_a", cor_tag, 8'h61);
    repeat (5) next_cycle();
    @(negedge clk);
    check_output("hold_tag_b", {cor_valid, cor_tag, cor_status}, {1'b1, 8'h61, 2'd0});
    next_cycle();
    cor_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clk);
      if (cor_valid) begin
        check_output("drain_tag", cor_tag, 8'(8'h61 + k));
        k++;
      end
      next_cycle();
    end
    check_output("drain_count", k, 5);
    check_output("stats_after_drain", {cnt_clean, cnt_corr, cnt_fail}, {16'd7, 16'd2, 16'd1});

    // reset while WAITing with two sets queued
    syn_valid = 1'b1; syn_tag = 8'h71; {syn_s3, syn_s2, syn_s1, syn_s0} = 32'h71717171;
    @(negedge clk);
    next_cycle();
    syn_tag = 8'h72; {syn_s3, syn_s2, syn_s1, syn_s0} = 32'h72727272;
    @(negedge clk);
    check_output("q_dispatch", rs_syn_ready, 1);
    next_cycle();
    rs_done = 1'b0;
    syn_tag = 8'h73; {syn_s3, syn_s2, syn_s1, syn_s0} = 32'h73737373;
    @(negedge clk);
    next_cycle();
    syn_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rs_done = 1'b1;
    #1;
    check_reset_values();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw |= rs_syn_ready;
      next_cycle();
    end
    check_output("post_reset_empty", saw, 0);
    apply_stimulus(8'h81, 32'h5A5A5A5A, 0, 34'h0);
    @(negedge clk);
    check_record(8'h81, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("post_reset_cnt", {cnt_clean, cnt_corr, cnt_fail}, {16'd1, 16'd0, 16'd0});
    next_cycle();

    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    @(negedge clk);
    check_output("stat_clr", {cnt_clean, cnt_corr, cnt_fail}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
